// File: rtl/decode_rf_scoreboard.sv
// Decode-stage register file with a pending-write scoreboard, WB-to-read bypass and ID pipeline register.
// Latency: Hazard is combinational from IF inputs; operands reach the ID outputs 1 cycle after issue.
// Backpressure: AnyStall blocks issue and holds the ID outputs; writeback is never held off.
module decode_rf_scoreboard #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned NREG   = 32,
  parameter int unsigned PEND_W = 2,
  localparam int unsigned AW    = $clog2(NREG)
) (
  input  logic             clk,
  input  logic             flush,
  input  logic             AnyStall,
  input  logic             Valid_IF,
  input  logic [AW-1:0]    RaA_IF,
  input  logic [AW-1:0]    RaB_IF,
  input  logic             UseA_IF,
  input  logic             UseB_IF,
  input  logic [AW-1:0]    Wa_IF,
  input  logic             WrDst_IF,
  input  logic             WrEn_WB,
  input  logic [AW-1:0]    WrReg_WB,
  input  logic [WIDTH-1:0] WrDat_WB,
  output logic             Hazard,
  output logic             Valid_ID,
  output logic [WIDTH-1:0] RdDatA_ID,
  output logic [WIDTH-1:0] RdDatB_ID,
  output logic [AW-1:0]    Wa_ID,
  output logic             SbErr
);

  localparam logic [PEND_W-1:0] PEND_MAX = {PEND_W{1'b1}};
  localparam logic [PEND_W-1:0] CNT_ZERO = '0;
  localparam logic [PEND_W-1:0] CNT_ONE  = PEND_W'(1);
  localparam logic [AW-1:0]     R0       = '0;

  // Architectural state: data array and one outstanding-write counter per register.
  // Entry 0 of both arrays is held at zero so r0 reads 0 and is never busy.
  logic [WIDTH-1:0]  rf  [NREG];
  logic [PEND_W-1:0] cnt [NREG];

  logic             wb_wr;        // writeback to a real (nonzero) register
  logic             retire;       // writeback that clears a pending write
  logic             bypass_a;
  logic             bypass_b;
  logic [WIDTH-1:0] opnd_a;
  logic [WIDTH-1:0] opnd_b;
  logic             busy_a;
  logic             busy_b;
  logic             waw;
  logic             issue;
  logic [NREG-1:0]  inc_vec;
  logic [NREG-1:0]  dec_vec;

  assign wb_wr  = WrEn_WB && (WrReg_WB != R0);
  assign retire = wb_wr && (cnt[WrReg_WB] != CNT_ZERO);

  // Operand selection: same-cycle writeback wins over the array; r0 is hard zero.
  always_comb begin
    bypass_a = wb_wr && (WrReg_WB == RaA_IF);
    bypass_b = wb_wr && (WrReg_WB == RaB_IF);
    opnd_a   = '0;
    opnd_b   = '0;
    if (bypass_a)             opnd_a = WrDat_WB;
    else if (RaA_IF != R0)    opnd_a = rf[RaA_IF];
    if (bypass_b)             opnd_b = WrDat_WB;
    else if (RaB_IF != R0)    opnd_b = rf[RaB_IF];
  end

  // Hazard detection. A retire only clears a RAW when it is the last pending
  // write; with two or more in flight the bypassed value is already stale.
  // A saturated destination counter blocks a further write unless a retire
  // frees a slot in the same cycle.
  always_comb begin
    busy_a = UseA_IF && (RaA_IF != R0) && (cnt[RaA_IF] != CNT_ZERO)
             && !((cnt[RaA_IF] == CNT_ONE) && retire && (WrReg_WB == RaA_IF));
    busy_b = UseB_IF && (RaB_IF != R0) && (cnt[RaB_IF] != CNT_ZERO)
             && !((cnt[RaB_IF] == CNT_ONE) && retire && (WrReg_WB == RaB_IF));
    waw    = WrDst_IF && (Wa_IF != R0) && (cnt[Wa_IF] == PEND_MAX)
             && !(retire && (WrReg_WB == Wa_IF));
    Hazard = Valid_IF && (busy_a || busy_b || waw);
    issue  = Valid_IF && !AnyStall && !Hazard;
  end

  // Per-register increment/decrement requests for this cycle.
  always_comb begin
    inc_vec = '0;
    dec_vec = '0;
    if (issue && WrDst_IF && (Wa_IF != R0)) inc_vec[Wa_IF]    = 1'b1;
    if (retire)                             dec_vec[WrReg_WB] = 1'b1;
  end

  // Pending-write counters; simultaneous issue and retire on one register cancel.
  always_ff @(posedge clk or posedge flush) begin
    if (flush) begin
      for (int r = 0; r < NREG; r++) cnt[r] <= '0;
    end else begin
      cnt[0] <= '0;
      for (int r = 1; r < NREG; r++) begin
        if (inc_vec[r] && !dec_vec[r])      cnt[r] <= cnt[r] + CNT_ONE;
        else if (dec_vec[r] && !inc_vec[r]) cnt[r] <= cnt[r] - CNT_ONE;
      end
    end
  end

  // Register array: writeback lands unconditionally, independent of stall or hazard.
  always_ff @(posedge clk or posedge flush) begin
    if (flush) begin
      for (int r = 0; r < NREG; r++) rf[r] <= '0;
    end else if (wb_wr) begin
      rf[WrReg_WB] <= WrDat_WB;
    end
  end

  // Sticky error: writeback arrived for a register with nothing pending.
  always_ff @(posedge clk or posedge flush) begin
    if (flush)                                           SbErr <= 1'b0;
    else if (wb_wr && (cnt[WrReg_WB] == CNT_ZERO))       SbErr <= 1'b1;
  end

  // ID pipeline register: hold on stall, load operands on issue, else insert a bubble.
  always_ff @(posedge clk or posedge flush) begin
    if (flush) begin
      Valid_ID  <= 1'b0;
      RdDatA_ID <= '0;
      RdDatB_ID <= '0;
      Wa_ID     <= '0;
    end else if (!AnyStall) begin
      Valid_ID <= issue;
      if (issue) begin
        RdDatA_ID <= opnd_a;
        RdDatB_ID <= opnd_b;
        Wa_ID     <= WrDst_IF ? Wa_IF : R0;
      end else begin
        RdDatA_ID <= '0;
        RdDatB_ID <= '0;
        Wa_ID     <= '0;
      end
    end
  end

endmodule

// File: tb/tb_decode_rf_scoreboard.sv
// Directed-vector bench for decode_rf_scoreboard with hand-computed expectations.
// Inputs change 1ns after each rising edge; outputs are sampled 1ns later.
// Runs a fixed number of cycles, so it always terminates.
module tb_decode_rf_scoreboard;

  localparam int W  = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          flush;
  logic          AnyStall;
  logic          Valid_IF;
  logic [AW-1:0] RaA_IF, RaB_IF, Wa_IF, WrReg_WB;
  logic          UseA_IF, UseB_IF, WrDst_IF, WrEn_WB;
  logic [W-1:0]  WrDat_WB;
  logic          Hazard, Valid_ID, SbErr;
  logic [W-1:0]  RdDatA_ID, RdDatB_ID;
  logic [AW-1:0] Wa_ID;

  int n_vec = 0;
  int n_err = 0;

  decode_rf_scoreboard #(.WIDTH(32), .NREG(32), .PEND_W(2)) dut (
    .clk(clk), .flush(flush), .AnyStall(AnyStall), .Valid_IF(Valid_IF),
    .RaA_IF(RaA_IF), .RaB_IF(RaB_IF), .UseA_IF(UseA_IF), .UseB_IF(UseB_IF),
    .Wa_IF(Wa_IF), .WrDst_IF(WrDst_IF), .WrEn_WB(WrEn_WB), .WrReg_WB(WrReg_WB),
    .WrDat_WB(WrDat_WB), .Hazard(Hazard), .Valid_ID(Valid_ID),
    .RdDatA_ID(RdDatA_ID), .RdDatB_ID(RdDatB_ID), .Wa_ID(Wa_ID), .SbErr(SbErr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv_if(input logic v, input logic ua, input logic [AW-1:0] ra,
                        input logic ub, input logic [AW-1:0] rb,
                        input logic wd, input logic [AW-1:0] wa);
    Valid_IF = v; UseA_IF = ua; RaA_IF = ra; UseB_IF = ub; RaB_IF = rb;
    WrDst_IF = wd; Wa_IF = wa;
  endtask

  task automatic drv_wb(input logic en, input logic [AW-1:0] r, input logic [W-1:0] d);
    WrEn_WB = en; WrReg_WB = r; WrDat_WB = d;
  endtask

  initial begin
    flush = 1'b1; AnyStall = 1'b0;
    drv_if(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
    drv_wb(1'b0, 5'd0, 32'h0);
    #12;
    // Reset state
    chk("rst_valid", {31'b0, Valid_ID}, 32'd0);
    chk("rst_rda",   RdDatA_ID, 32'd0);
    chk("rst_wa",    {27'b0, Wa_ID}, 32'd0);
    chk("rst_sberr", {31'b0, SbErr}, 32'd0);
    chk("rst_haz",   {31'b0, Hazard}, 32'd0);
    flush = 1'b0;
    tick();

    // Bypass: r3 pending once, WB r3 retires it while IF reads r3
    drv_if(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd3);
    #1 chk("byp_iss_haz", {31'b0, Hazard}, 32'd0);
    tick();
    chk("byp_iss_vld", {31'b0, Valid_ID}, 32'd1);
    chk("byp_iss_wa",  {27'b0, Wa_ID}, 32'd3);
    drv_if(1'b1, 1'b1, 5'd3, 1'b0, 5'd0, 1'b0, 5'd0);
    drv_wb(1'b1, 5'd3, 32'hDEADBEEF);
    #1 chk("byp_haz", {31'b0, Hazard}, 32'd0);
    tick();
    chk("byp_rda", RdDatA_ID, 32'hDEADBEEF);
    chk("byp_wa0", {27'b0, Wa_ID}, 32'd0);
    drv_wb(1'b0, 5'd0, 32'h0);
    #1 chk("byp_cnt0_haz", {31'b0, Hazard}, 32'd0);
    tick();
    chk("byp_array_rda", RdDatA_ID, 32'hDEADBEEF);

    // RAW stall on r7
    drv_if(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd7);
    tick();
    drv_if(1'b1, 1'b0, 5'd0, 1'b1, 5'd7, 1'b0, 5'd0);
    for (int i = 0; i < 4; i++) begin
      #1 chk("raw_haz", {31'b0, Hazard}, 32'd1);
      tick();
      chk("raw_bubble_vld", {31'b0, Valid_ID}, 32'd0);
      chk("raw_bubble_rdb", RdDatB_ID, 32'd0);
    end
    drv_wb(1'b1, 5'd7, 32'h12);
    #1 chk("raw_wb_haz", {31'b0, Hazard}, 32'd0);
    tick();
    chk("raw_wb_vld", {31'b0, Valid_ID}, 32'd1);
    chk("raw_wb_rdb", RdDatB_ID, 32'h12);
    drv_wb(1'b0, 5'd0, 32'h0);

    // WAW saturation on r9
    drv_if(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd9);
    for (int i = 0; i < 3; i++) begin
      #1 chk("waw_fill_haz", {31'b0, Hazard}, 32'd0);
      tick();
    end
    #1 chk("waw_full_haz", {31'b0, Hazard}, 32'd1);
    tick();
    chk("waw_full_vld", {31'b0, Valid_ID}, 32'd0);
    drv_wb(1'b1, 5'd9, 32'h99);
    #1 chk("waw_retire_haz", {31'b0, Hazard}, 32'd0);
    tick();
    chk("waw_retire_vld", {31'b0, Valid_ID}, 32'd1);
    chk("waw_retire_wa",  {27'b0, Wa_ID}, 32'd9);
    drv_wb(1'b0, 5'd0, 32'h0);
    #1 chk("waw_still3_haz", {31'b0, Hazard}, 32'd1);
    tick();
    drv_if(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
    drv_wb(1'b1, 5'd9, 32'h91);
    tick();
    drv_if(1'b1, 1'b1, 5'd9, 1'b0, 5'd0, 1'b0, 5'd0);
    drv_wb(1'b1, 5'd9, 32'h92);
    #1 chk("raw_cnt2_haz", {31'b0, Hazard}, 32'd1);
    tick();
    chk("raw_cnt2_vld", {31'b0, Valid_ID}, 32'd0);
    drv_wb(1'b1, 5'd9, 32'h93);
    #1 chk("raw_cnt1_haz", {31'b0, Hazard}, 32'd0);
    tick();
    chk("raw_cnt1_rda", RdDatA_ID, 32'h93);
    drv_wb(1'b0, 5'd0, 32'h0);

    // Stall hold
    drv_if(1'b1, 1'b1, 5'd3, 1'b0, 5'd0, 1'b1, 5'd10);
    tick();
    chk("stl_pre_wa", {27'b0, Wa_ID}, 32'd10);
    AnyStall = 1'b1;
    drv_if(1'b1, 1'b1, 5'd7, 1'b0, 5'd0, 1'b1, 5'd11);
    for (int i = 0; i < 3; i++) begin
      if (i == 1) drv_wb(1'b1, 5'd10, 32'hA5A5A5A5);
      else        drv_wb(1'b0, 5'd0, 32'h0);
      #1 chk("stl_haz", {31'b0, Hazard}, 32'd0);
      tick();
      chk("stl_vld", {31'b0, Valid_ID}, 32'd1);
      chk("stl_wa",  {27'b0, Wa_ID}, 32'd10);
      chk("stl_rda", RdDatA_ID, 32'hDEADBEEF);
    end
    AnyStall = 1'b0;
    drv_wb(1'b0, 5'd0, 32'h0);
    drv_if(1'b1, 1'b1, 5'd11, 1'b1, 5'd10, 1'b0, 5'd0);
    #1 chk("stl_post_haz", {31'b0, Hazard}, 32'd0);
    tick();
    chk("stl_post_rdb", RdDatB_ID, 32'hA5A5A5A5);
    chk("stl_post_rda", RdDatA_ID, 32'd0);
    chk("stl_sberr",    {31'b0, SbErr}, 32'd0);

    // Scoreboard error and r0
    drv_if(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
    drv_wb(1'b1, 5'd4, 32'h44);
    tick();
    chk("err_sberr", {31'b0, SbErr}, 32'd1);
    drv_wb(1'b0, 5'd0, 32'h0);
    drv_if(1'b1, 1'b1, 5'd4, 1'b0, 5'd0, 1'b1, 5'd0);
    #1 chk("err_r4_haz", {31'b0, Hazard}, 32'd0);
    tick();
    chk("err_r4_rda", RdDatA_ID, 32'h44);
    chk("r0_wa",      {27'b0, Wa_ID}, 32'd0);
    drv_if(1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
    drv_wb(1'b1, 5'd0, 32'hFFFF);
    #1 chk("r0_haz", {31'b0, Hazard}, 32'd0);
    tick();
    chk("r0_rda",   RdDatA_ID, 32'd0);
    chk("r0_sberr", {31'b0, SbErr}, 32'd1);
    drv_wb(1'b0, 5'd0, 32'h0);

    // Flush mid-operation with r5 pending twice
    drv_if(1'b1, 1'b1, 5'd4, 1'b0, 5'd0, 1'b1, 5'd5);
    tick();
    tick();
    chk("fl_pre_wa",  {27'b0, Wa_ID}, 32'd5);
    chk("fl_pre_rda", RdDatA_ID, 32'h44);
    drv_if(1'b1, 1'b1, 5'd5, 1'b0, 5'd0, 1'b0, 5'd0);
    #1 chk("fl_pre_haz", {31'b0, Hazard}, 32'd1);
    flush = 1'b1;
    #1;
    chk("fl_vld",   {31'b0, Valid_ID}, 32'd0);
    chk("fl_rda",   RdDatA_ID, 32'd0);
    chk("fl_wa",    {27'b0, Wa_ID}, 32'd0);
    chk("fl_sberr", {31'b0, SbErr}, 32'd0);
    chk("fl_haz",   {31'b0, Hazard}, 32'd0);
    tick();
    chk("fl_hold_vld", {31'b0, Valid_ID}, 32'd0);
    flush = 1'b0;
    drv_if(1'b1, 1'b1, 5'd5, 1'b1, 5'd4, 1'b0, 5'd0);
    #1 chk("fl_post_haz", {31'b0, Hazard}, 32'd0);
    tick();
    chk("fl_post_vld", {31'b0, Valid_ID}, 32'd1);
    chk("fl_post_rda", RdDatA_ID, 32'd0);
    chk("fl_post_rdb", RdDatB_ID, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
